core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I scalar core.
- Fetches instruction words over a req/ack instruction-memory port and holds the word stable for the combinational instruction decoder.
- Consumes the decoder's one-hot instruction-class flags and the branch compare result.
- Sequences execute, data-memory access and register-file writeback, and owns the architectural PC.

---
 rtl/core_sequencer.sv | 154 +++++++++++++++
 tb/tb_core_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32I scalar core.
// Fetch, decode, execute, memory and writeback steps; owns the architectural PC.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  input  logic        is_addi,
  input  logic        is_add,
  input  logic        is_beq,
  input  logic        is_jal,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] imm,
  input  logic        br_eq,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] pc,
  output logic        retired,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] C_ILLEGAL  = 2'd1;
  localparam logic [1:0] C_MISALIGN = 2'd2;
  localparam logic [1:0] C_TIMEOUT  = 2'd3;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     npc_q, npc_d;
  logic [1:0]      cause_q, cause_d;
  logic [WW-1:0]   wait_q, wait_d;
  // class latched in DECODE: {beq, jal, load, store}
  logic [3:0]      cls_q, cls_d;
  logic [31:0]     tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      npc_q   <= '0;
      cause_q <= '0;
      wait_q  <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    cause_d  = cause_q;
    wait_d   = wait_q;
    cls_d    = cls_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    retired  = 1'b0;
    tgt      = pc_q + 32'd4;
    unique case (state_q)
      S_FETCH: begin
        imem_req = ~rst;
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          cause_d = C_TIMEOUT;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d = {is_beq, is_jal, is_load, is_store};
        if ($onehot({is_addi, is_add, is_beq, is_jal, is_load, is_store})) begin
          state_d = S_EXEC;
        end else begin
          cause_d = C_ILLEGAL;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (cls_q[2] || (cls_q[3] && br_eq)) tgt = pc_q + imm;
        if (tgt[1:0] != 2'b00) begin
          cause_d = C_MISALIGN;
          state_d = S_HALT;
        end else begin
          npc_d   = tgt;
          state_d = (cls_q[1] || cls_q[0]) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dmem_req = ~rst;
        dmem_we  = cls_q[0];
        if (dmem_ack) begin
          wait_d  = '0;
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          cause_d = C_TIMEOUT;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = ~(cls_q[3] | cls_q[0]);
        wb_sel  = cls_q[2] ? 2'd1 : (cls_q[1] ? 2'd2 : 2'd0);
        pc_d    = npc_q;
        retired = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr_raw  = instr_q;
  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a scoreboard of expected retirements.
// Instruction memory and data memory are simple responders driven by the bench.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instr_raw;
  logic        is_addi, is_add, is_beq, is_jal, is_load, is_store;
  logic [31:0] imm;
  logic        br_eq;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic        retired, halted;
  logic [1:0]  halt_cause;

  logic        imem_auto, imem_force;
  int          dly;
  logic [3:0]  dcnt;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] word;
    logic        rf;
    logic [1:0]  sel;
    int          lat;
    int          dcyc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  assign imem_ack = (imem_auto & imem_req) | imem_force;

  always @(posedge clk) begin
    if (!dmem_req) dcnt <= '0;
    else           dcnt <= dcnt + 4'd1;
  end
  assign dmem_ack = dmem_req && (int'(dcnt) == dly);

  core_sequencer #(.RESET_PC(32'h100), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_raw(instr_raw),
    .is_addi(is_addi), .is_add(is_add), .is_beq(is_beq),
    .is_jal(is_jal), .is_load(is_load), .is_store(is_store),
    .imm(imm), .br_eq(br_eq),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc),
    .retired(retired), .halted(halted), .halt_cause(halt_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // cls = {addi, add, beq, jal, load, store}
  task automatic run_instr(input string nm, input logic [5:0] cls,
                           input logic [31:0] im, input logic eq,
                           input int d, input logic [31:0] word,
                           input logic [31:0] npc, input logic we);
    exp_t e;
    int   n;
    int   dc;
    logic weok;
    e.npc  = npc;
    e.word = word;
    e.rf   = cls[5] | cls[4] | cls[2] | cls[1];
    e.sel  = cls[2] ? 2'd1 : (cls[1] ? 2'd2 : 2'd0);
    e.lat  = (cls[1] | cls[0]) ? 5 + d : 4;
    e.dcyc = (cls[1] | cls[0]) ? d + 1 : 0;
    sb.push_back(e);
    {is_addi, is_add, is_beq, is_jal, is_load, is_store} = cls;
    imm = im; br_eq = eq; dly = d; imem_rdata = word;
    chk({nm, ".addr"}, imem_addr, cur_pc);
    n = 1; dc = 0; weok = 1'b1;
    while (!retired && n < 30) begin
      @(negedge clk);
      n++;
      if (dmem_req) begin
        dc++;
        if (dmem_we !== we) weok = 1'b0;
      end
    end
    e = sb.pop_front();
    chk({nm, ".lat"}, n, e.lat);
    chk({nm, ".rf_we"}, rf_we, e.rf);
    chk({nm, ".wb_sel"}, wb_sel, e.sel);
    chk({nm, ".instr"}, instr_raw, e.word);
    chk({nm, ".dreq"}, dc, e.dcyc);
    chk({nm, ".dwe"}, weok, 1);
    @(negedge clk);
    chk({nm, ".pc"}, pc, e.npc);
    cur_pc = e.npc;
  endtask

  task automatic wait_halt(input string nm, input logic [1:0] cause,
                           input logic [31:0] hpc);
    int n;
    n = 0;
    while (!halted && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".halted"}, halted, 1);
    chk({nm, ".cause"}, halt_cause, cause);
    chk({nm, ".pc"}, pc, hpc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst.req", imem_req, 0);
    chk("rst.halted", halted, 0);
    chk("rst.pc", pc, 32'h100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cur_pc = 32'h100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst = 1'b1;
    imem_auto = 1'b1; imem_force = 1'b0;
    {is_addi, is_add, is_beq, is_jal, is_load, is_store} = '0;
    imm = '0; br_eq = 1'b0; dly = 0; imem_rdata = '0;
    #1;
    chk("reset.pc", pc, 32'h100);
    chk("reset.instr", instr_raw, 0);
    chk("reset.req", {imem_req, dmem_req, rf_we, retired}, 0);
    chk("reset.halt", {halted, halt_cause}, 0);
    chk("reset.wb_sel", wb_sel, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    cur_pc = 32'h100;

    run_instr("addi",   6'b100000, 32'd5,        0, 0, 32'h0050_0093, 32'h104, 0);
    run_instr("jal1",   6'b000100, 32'h0FC,      0, 0, 32'h0FC0_006F, 32'h200, 0);
    run_instr("beq_t",  6'b001000, 32'hFFFF_FFF8, 1, 0, 32'hFE00_0CE3, 32'h1F8, 0);
    run_instr("jal2",   6'b000100, 32'd8,        0, 0, 32'h0080_006F, 32'h200, 0);
    run_instr("beq_n",  6'b001000, 32'hFFFF_FFF8, 0, 0, 32'hFE00_0CE3, 32'h204, 0);
    run_instr("jal3",   6'b000100, 32'hFFFF_FDF8, 0, 0, 32'hDF9F_F06F, 32'hFFFF_FFFC, 0);
    run_instr("jalw",   6'b000100, 32'd8,        0, 0, 32'h0080_006F, 32'h4, 0);
    run_instr("load",   6'b000010, 32'd0,        0, 3, 32'h0000_2083, 32'h8, 0);
    run_instr("store",  6'b000001, 32'd0,        0, 0, 32'h0010_2023, 32'hC, 1);
    run_instr("add",    6'b010000, 32'd0,        0, 0, 32'h0020_80B3, 32'h10, 0);

    {is_addi, is_add, is_beq, is_jal, is_load, is_store} = '0;
    imem_rdata = 32'hFFFF_FFFF;
    wait_halt("illegal", 2'd1, 32'h10);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req || retired) hi++;
    end
    chk("illegal.quiet", hi, 0);
    chk("illegal.sticky", {halted, halt_cause}, 3'b101);

    do_reset();
    {is_addi, is_add, is_beq, is_jal, is_load, is_store} = 6'b000100;
    imm = 32'd2;
    wait_halt("misalign", 2'd2, 32'h100);

    do_reset();
    imem_auto = 1'b0;
    wait_halt("timeout", 2'd3, 32'h100);
    chk("timeout.req", imem_req, 0);

    do_reset();
    imem_auto = 1'b1;
    run_instr("addi2",  6'b100000, 32'd1,        0, 0, 32'h0010_0093, 32'h104, 0);
    imem_auto = 1'b0;
    @(negedge clk);
    chk("midf.req", imem_req, 1);
    chk("midf.addr", imem_addr, 32'h104);
    rst = 1'b1;
    #1;
    chk("midf.drop", imem_req, 0);
    chk("midf.pc", pc, 32'h100);
    chk("midf.instr", instr_raw, 0);
    imem_rdata = 32'hDEAD_BEEF;
    imem_force = 1'b1;
    @(posedge clk);
    #1;
    imem_force = 1'b0;
    chk("late.instr", instr_raw, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart.addr", imem_addr, 32'h100);
    chk("restart.req", imem_req, 1);
    imem_auto = 1'b1;
    cur_pc = 32'h100;
    run_instr("addi3",  6'b100000, 32'd2,        0, 0, 32'h0020_0093, 32'h104, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
